// File: rtl/mem_copy_engine.sv
// Memory copy/fill engine: moves a block of words through the single-port data memory
// (copy: M[dst+i] <= M[src+i], fill: M[dst+i] <= fill_val) and reports busy/done/progress.
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned MAX_LEN = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cur_q, cur_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              busy_d;
  logic              done_d;
  logic [LEN_W-1:0]  words_done_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_rd_en_d;
  logic              mem_wr_en_d;
  logic [DATA_W-1:0] mem_wdata_d;

  logic [LEN_W-1:0]  len_clamped_c;
  logic [LEN_W-1:0]  cur_inc_c;

  // Oversized requests are limited to one full pass over the address space.
  assign len_clamped_c = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign cur_inc_c     = cur_q + LEN_W'(1);

  // Next state, transfer context and the registered bus/status values for the next cycle.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    len_d        = len_q;
    src_d        = src_q;
    dst_d        = dst_q;
    fill_d       = fill_q;
    mode_d       = mode_q;
    data_d       = data_q;
    words_done_d = words_done;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d        = len_clamped_c;
          src_d        = src_addr;
          dst_d        = dst_addr;
          fill_d       = fill_val;
          mode_d       = mode;
          cur_d        = '0;
          words_done_d = '0;
          if (len_clamped_c == '0) begin
            state_d = DONE;
          end else if (mode) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        data_d = mem_rdata;
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        // The write presented this cycle is committed and counted even when aborted.
        words_done_d = words_done + LEN_W'(1);
        cur_d        = cur_inc_c;
        if (abort) begin
          state_d = IDLE;
        end else if (cur_inc_c == len_q) begin
          state_d = DONE;
        end else if (mode_q) begin
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d == READ) || (state_d == WRITE);
    done_d      = (state_d == DONE);
    mem_rd_en_d = (state_d == READ);
    mem_wr_en_d = (state_d == WRITE);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == READ) begin
      mem_addr_d = src_d + ADDR_W'(cur_d);
    end else if (state_d == WRITE) begin
      mem_addr_d  = dst_d + ADDR_W'(cur_d);
      mem_wdata_d = mode_d ? fill_d : data_d;
    end
  end

  // State, context and output registers; reset clears every output immediately.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      len_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      fill_q     <= '0;
      mode_q     <= 1'b0;
      data_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_done <= '0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      len_q      <= len_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      fill_q     <= fill_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      busy       <= busy_d;
      done       <= done_d;
      words_done <= words_done_d;
      mem_addr   <= mem_addr_d;
      mem_rd_en  <= mem_rd_en_d;
      mem_wr_en  <= mem_wr_en_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural memory, transaction-level reference model and
// per-cycle comparison of the engine's bus and status outputs.
module tb_mem_copy_engine;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [8:0] len = '0;
  logic [7:0] fill_val = '0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic [8:0] words_done;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  wire  [7:0] mem_rdata;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  int nchk = 0;
  int nfail = 0;

  // One expected bus cycle while the engine is active.
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       dn;
    logic [7:0] addr;
    logic [7:0] wdata;
  } exp_t;

  exp_t exp_q [$];
  int   exp_wd = 0;

  logic [7:0] rd_log [$];
  int         wr_seen;

  mem_copy_engine dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_val   (fill_val),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Single-port memory: combinational read, write on the clock edge.
  assign mem_rdata = mem_rd_en ? mem[mem_addr] : 8'hzz;
  initial forever begin
    @(posedge CLK);
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_mem(input string nm);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(nm, bad, 0);
  endtask

  // Reference model and per-cycle compare: a transfer is expanded into its full list of
  // bus cycles when accepted; abort and reset drop whatever has not happened yet.
  initial begin : cmp
    exp_t       e;
    exp_t       ne;
    int         n;
    logic [7:0] v;
    logic [7:0] tmp [256];
    forever begin
      @(negedge CLK or negedge reset);
      if (!reset) begin
        exp_q.delete();
        exp_wd = 0;
      end
      if (CLK == 1'b0) begin
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk("rd_en", mem_rd_en, e.rd);
        chk("wr_en", mem_wr_en, e.wr);
        chk("busy", busy, e.rd | e.wr);
        chk("done", done, e.dn);
        chk("words_done", words_done, exp_wd);
        if (e.rd) chk("rd_addr", mem_addr, e.addr);
        if (e.wr) begin
          chk("wr_addr", mem_addr, e.addr);
          chk("wdata", mem_wdata, e.wdata);
          ref_mem[e.addr] = e.wdata;
          exp_wd++;
        end
        if (reset) begin
          if ((e.rd || e.wr) && abort) begin
            exp_q.delete();
          end else if (!e.rd && !e.wr && !e.dn && exp_q.size() == 0 && start) begin
            n = (int'(len) > 256) ? 256 : int'(len);
            tmp = ref_mem;
            for (int i = 0; i < n; i++) begin
              if (!mode) begin
                ne = '{rd: 1'b1, wr: 1'b0, dn: 1'b0, addr: 8'(src_addr + i), wdata: 8'h00};
                exp_q.push_back(ne);
              end
              v = mode ? fill_val : tmp[8'(src_addr + i)];
              tmp[8'(dst_addr + i)] = v;
              ne = '{rd: 1'b0, wr: 1'b1, dn: 1'b0, addr: 8'(dst_addr + i), wdata: v};
              exp_q.push_back(ne);
            end
            ne = '{rd: 1'b0, wr: 1'b0, dn: 1'b1, addr: 8'h00, wdata: 8'h00};
            exp_q.push_back(ne);
            exp_wd = 0;
          end
        end
      end
    end
  end

  // Issue one transfer; optionally raise abort or a stray start in a given cycle after
  // the start edge (cycle 1 = first cycle after it). cyc = cycle of done, -1 if aborted.
  task automatic run_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input int ln, input logic [7:0] f, input int abort_at,
                          input int poke_at, output int cyc);
    int n;
    int lim;
    n   = (ln > 256) ? 256 : ln;
    lim = (m ? n : 2 * n) + 4;
    rd_log.delete();
    wr_seen = 0;
    cyc = 0;
    @(posedge CLK); #1;
    mode = m; src_addr = s; dst_addr = d; len = 9'(ln); fill_val = f; start = 1'b1;
    for (int c = 1; c <= lim; c++) begin
      @(posedge CLK); #1;
      start = (c == poke_at);
      if (c == poke_at) begin
        mode = ~m; len = 9'd1; src_addr = 8'h00; dst_addr = 8'h00;
      end
      abort = (c == abort_at);
      @(negedge CLK);
      if (mem_rd_en) rd_log.push_back(mem_addr);
      if (mem_wr_en) wr_seen++;
      if (done) begin
        cyc = c;
        break;
      end
      if (abort) begin
        cyc = -1;
        break;
      end
    end
    if (cyc == 0) chk("done_timeout", 1, 0);
    @(posedge CLK); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge CLK);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int         cyc;
    int         ab;
    int         ln;
    logic [7:0] exp3 [4];
    exp3 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_words", words_done, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    #11 reset = 1'b1;
    repeat (2) @(negedge CLK);

    // Basic copy
    mem[8'h10] = 8'd254; mem[8'h11] = 8'd7; mem[8'h12] = 8'd9;
    ref_mem[8'h10] = 8'd254; ref_mem[8'h11] = 8'd7; ref_mem[8'h12] = 8'd9;
    run_xfer(1'b0, 8'h10, 8'h80, 3, 8'h00, 0, 0, cyc);
    chk("t1_cycles", cyc, 7);
    chk("t1_words", words_done, 3);
    chk("t1_m80", mem[8'h80], 254);
    chk("t1_m81", mem[8'h81], 7);
    chk("t1_m82", mem[8'h82], 9);
    chk_mem("t1_mem");

    // Fill
    run_xfer(1'b1, 8'h00, 8'hF0, 4, 8'h5A, 0, 0, cyc);
    chk("t2_cycles", cyc, 5);
    chk("t2_reads", rd_log.size(), 0);
    chk("t2_mF0", mem[8'hF0], 8'h5A);
    chk("t2_mF3", mem[8'hF3], 8'h5A);
    chk_mem("t2_mem");

    // Copy with source wrap
    run_xfer(1'b0, 8'hFE, 8'h40, 4, 8'h00, 0, 0, cyc);
    chk("t3_nreads", rd_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_rd_seq", (i < rd_log.size()) ? rd_log[i] : 8'hxx, exp3[i]);
    chk("t3_m40", mem[8'h40], ref_mem[8'h40]);
    chk_mem("t3_mem");

    // Zero length
    run_xfer(1'b0, 8'h20, 8'h30, 0, 8'h00, 0, 0, cyc);
    chk("t4_cycles", cyc, 1);
    chk("t4_reads", rd_log.size(), 0);
    chk("t4_writes", wr_seen, 0);
    chk("t4_words", words_done, 0);

    // Abort during the third write, with a stray start while busy
    run_xfer(1'b0, 8'h50, 8'hA0, 10, 8'h00, 6, 2, cyc);
    chk("t5_aborted", cyc, -1);
    chk("t5_writes", wr_seen, 3);
    chk("t5_words", words_done, 3);
    chk("t5_busy", busy, 0);
    chk_mem("t5_mem");

    // Abort on the final write of a fill: write still counted, no done
    run_xfer(1'b1, 8'h00, 8'hC0, 5, 8'h3C, 5, 0, cyc);
    chk("t5b_aborted", cyc, -1);
    chk("t5b_words", words_done, 5);
    chk_mem("t5b_mem");

    // Reset between edges in the middle of a copy, then a clean restart
    @(posedge CLK); #1;
    mode = 1'b0; src_addr = 8'h20; dst_addr = 8'h60; len = 9'd8; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (4) @(posedge CLK);
    #2 reset = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_rd_en", mem_rd_en, 0);
    chk("t6_wr_en", mem_wr_en, 0);
    chk("t6_words", words_done, 0);
    @(negedge CLK); #2 reset = 1'b1;
    run_xfer(1'b0, 8'h20, 8'h60, 8, 8'h00, 0, 0, cyc);
    chk("t6_cycles", cyc, 17);
    chk("t6_done_words", words_done, 8);
    chk_mem("t6_mem");

    // Length above the address space is clamped
    run_xfer(1'b1, 8'h00, 8'h07, 300, 8'hA5, 0, 0, cyc);
    chk("clamp_cycles", cyc, 257);
    chk("clamp_words", words_done, 256);
    chk_mem("clamp_mem");

    // Randomized transfers, including overlapping copies and random aborts
    for (int k = 0; k < 20; k++) begin
      ln = int'($urandom_range(0, 24));
      ab = 0;
      if (ln > 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(1, 2 * ln));
      if ($urandom_range(0, 1) == 1) begin
        run_xfer(1'b1, 8'($urandom), 8'($urandom), ln, 8'($urandom),
                 (ab > ln) ? ln : ab, 0, cyc);
      end else begin
        run_xfer(1'b0, 8'($urandom), 8'($urandom), ln, 8'h00, ab, 0, cyc);
      end
      chk_mem("rand_mem");
    end

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
